prog_moore_fsm: RTL and testbench



---
 rtl/prog_moore_pkg.sv | 14 +
 rtl/prog_moore_tab.sv | 41 ++++
 rtl/prog_moore_fsm.sv | 165 ++++++++++++++++
 tb/tb_prog_moore_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_moore_pkg.sv
// Shared constants and helpers for the programmable Moore FSM.
// Config select encodings and config data width derivation.
package prog_moore_pkg;

  localparam logic CFG_SEL_NEXT = 1'b0;
  localparam logic CFG_SEL_OUT  = 1'b1;

  localparam int CNT_W = 16;

  function automatic int cfg_wd(input int sw, input int ow);
    return (sw > ow) ? sw : ow;
  endfunction

endpackage

// File: rtl/prog_moore_tab.sv
// Register-array table: synchronous write, asynchronous read,
// per-entry reset value supplied by the instantiating module.
module prog_moore_tab #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int AW    = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DEPTH-1:0][WIDTH-1:0] rst_val_i,
  input  logic                        we_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic [AW-1:0]               rd_addr_i,
  output logic [WIDTH-1:0]            rd_data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= rst_val_i;
    end else if (we_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr_i == AW'(i)) begin
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == AW'(i)) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/prog_moore_fsm.sv
// Table-driven programmable Moore FSM stepping on handshaked symbols.
// Optional accepted-step counter enabled by PROG_MOORE_STEP_CNT_EN.
module prog_moore_fsm
  import prog_moore_pkg::*;
#(
  parameter  int N_STATES    = 8,
  parameter  int IN_W        = 1,
  parameter  int OUT_W       = 2,
  parameter  int RESET_STATE = 0,
  localparam int SW          = $clog2(N_STATES),
  localparam int WD          = cfg_wd(SW, OUT_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in_data,
  output logic               in_ready,
  input  logic               run,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [SW+IN_W-1:0] cfg_addr,
  input  logic [WD-1:0]      cfg_wdata,
  output logic [SW-1:0]      state,
  output logic [OUT_W-1:0]   out,
  output logic               err
`ifdef PROG_MOORE_STEP_CNT_EN
  ,
  output logic [CNT_W-1:0]   step_cnt
`endif
);

  localparam int AW     = SW + IN_W;
  localparam int NDEPTH = N_STATES << IN_W;

  localparam logic [SW:0]   NS     = (SW+1)'(N_STATES);
  localparam logic [SW-1:0] RST_ST = SW'(RESET_STATE);

  logic [SW-1:0]    state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;

  logic             step;
  logic [SW-1:0]    n_st, o_st;
  logic             n_we, o_we;
  logic             clr;
  logic [SW-1:0]    nxt_raw, tgt;
  logic             legal;
  logic [OUT_W-1:0] o_rd;
  logic             frz_edit;

  logic [NDEPTH-1:0][SW-1:0] n_rst;

  assign step = in_valid && run;

  assign n_st = cfg_addr[AW-1:IN_W];
  assign o_st = cfg_addr[SW-1:0];

`ifdef PROG_MOORE_STEP_CNT_EN
  assign clr = cfg_we && (cfg_sel == CFG_SEL_OUT) && (&o_st);
`else
  assign clr = 1'b0;
`endif

  assign n_we = cfg_we && (cfg_sel == CFG_SEL_NEXT) &&
                ({1'b0, n_st} < NS);
  assign o_we = cfg_we && (cfg_sel == CFG_SEL_OUT) &&
                ({1'b0, o_st} < NS) && !clr;

  // Each next-state entry defaults to a self-loop on its own state.
  for (genvar g = 0; g < NDEPTH; g++) begin : g_nrst
    assign n_rst[g] = SW'(g >> IN_W);
  end

  prog_moore_tab #(
    .DEPTH(NDEPTH),
    .WIDTH(SW),
    .AW   (AW)
  ) u_ntab (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_val_i(n_rst),
    .we_i     (n_we),
    .wr_addr_i(cfg_addr),
    .wr_data_i(cfg_wdata[SW-1:0]),
    .rd_addr_i({state_q, in_data}),
    .rd_data_o(nxt_raw)
  );

  assign legal = ({1'b0, nxt_raw} < NS);
  assign tgt   = legal ? nxt_raw : RST_ST;

  prog_moore_tab #(
    .DEPTH(N_STATES),
    .WIDTH(OUT_W),
    .AW   (SW)
  ) u_otab (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_val_i('0),
    .we_i     (o_we),
    .wr_addr_i(o_st),
    .wr_data_i(cfg_wdata[OUT_W-1:0]),
    .rd_addr_i(tgt),
    .rd_data_o(o_rd)
  );

  // Frozen displays follow edits to the current state's output.
  assign frz_edit = o_we && !run && (o_st == state_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = 1'b0;
    if (step) begin
      state_d = tgt;
      out_d   = o_rd;
      err_d   = !legal;
    end else if (frz_edit) begin
      out_d   = cfg_wdata[OUT_W-1:0];
    end
  end

  always_comb begin
    in_ready = run;
    state    = state_q;
    out      = out_q;
    err      = err_q;
  end

`ifdef PROG_MOORE_STEP_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign step_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Scoreboard bench for prog_moore_fsm: directed plan plus random traffic
// checked against a table-level behavioural model.
module tb_prog_moore_fsm;

  localparam int NS = 6;
  localparam int IW = 1;
  localparam int OW = 2;
  localparam int RS = 0;
  localparam int SW = 3;
  localparam int AW = 4;
  localparam int WD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready;
  logic          run = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [WD-1:0] cfg_wdata = '0;
  logic [SW-1:0] state;
  logic [OW-1:0] out;
  logic          err;
`ifdef PROG_MOORE_STEP_CNT_EN
  logic [15:0]   step_cnt;
`endif

  always #5 clk = ~clk;

  prog_moore_fsm #(
    .N_STATES   (NS),
    .IN_W       (IW),
    .OUT_W      (OW),
    .RESET_STATE(RS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .run      (run),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .state    (state),
    .out      (out),
    .err      (err)
`ifdef PROG_MOORE_STEP_CNT_EN
    ,
    .step_cnt (step_cnt)
`endif
  );

  typedef struct {
    int st;
    int o;
    int e;
    int rdy;
    int cnt;
  } exp_t;

  exp_t q[$];

  int m_nt[NS][2];
  int m_ot[NS];
  int m_s;
  int m_o;
  int m_cnt;

  int n_chk = 0;
  int n_fail = 0;

  int tn[NS][2] = '{'{1, 2}, '{4, 5}, '{1, 3}, '{1, 0}, '{4, 5}, '{3, 0}};
  int to[NS] = '{3, 1, 3, 2, 2, 0};
  int walk[6] = '{1, 1, 0, 0, 1, 1};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_nt[s][0] = s;
      m_nt[s][1] = s;
      m_ot[s] = 0;
    end
    m_s = RS;
    m_o = 0;
    m_cnt = 0;
  endtask

  // One clock of stimulus; the model predicts the post-edge outputs.
  task automatic cyc(input int rst, input int r, input int v, input int d,
                     input int we, input int sel, input int addr,
                     input int wd);
    exp_t e;
    int   n;
    int   st;
    bit   clr;
    @(negedge clk);
    rst_n     = (rst == 0);
    run       = r[0];
    in_valid  = v[0];
    in_data   = d[0];
    cfg_we    = we[0];
    cfg_sel   = sel[0];
    cfg_addr  = addr[3:0];
    cfg_wdata = wd[2:0];
    e.rdy = r & 1;
    e.e   = 0;
    if (rst != 0) begin
      model_reset();
    end else begin
      if (v != 0 && r != 0) begin
        n = m_nt[m_s][d & 1];
        if (n >= NS) begin
          m_s = RS;
          e.e = 1;
        end else begin
          m_s = n;
        end
        m_o = m_ot[m_s];
        if (m_cnt < 65535) m_cnt++;
      end
      clr = 1'b0;
`ifdef PROG_MOORE_STEP_CNT_EN
      clr = (we != 0) && (sel != 0) && ((addr & 7) == 7);
      if (clr) m_cnt = 0;
`endif
      if (we != 0 && !clr) begin
        if (sel == 0) begin
          st = (addr >> 1) & 7;
          if (st < NS) m_nt[st][addr & 1] = wd & 7;
        end else begin
          st = addr & 7;
          if (st < NS) begin
            m_ot[st] = wd & 3;
            if (r == 0 && st == m_s) m_o = wd & 3;
          end
        end
      end
    end
    e.st  = m_s;
    e.o   = m_o;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  always begin : mon
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", int'(state), e.st);
      chk("out", int'(out), e.o);
      chk("err", int'(err), e.e);
      chk("in_ready", int'(in_ready), e.rdy);
`ifdef PROG_MOORE_STEP_CNT_EN
      chk("step_cnt", int'(step_cnt), e.cnt);
`endif
    end
  end

  initial begin
    model_reset();

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, i & 1, 0, 0, 0, 0);

    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < 2; b++) cyc(0, 0, 0, 0, 1, 0, s * 2 + b, tn[s][b]);
    end
    for (int s = 0; s < NS; s++) cyc(0, 0, 0, 0, 1, 1, s, to[s]);

    for (int i = 0; i < 6; i++) cyc(0, 1, 1, walk[i], 0, 0, 0, 0);

    // Same-cycle write to the entry being used.
    cyc(0, 1, 1, 1, 1, 0, m_s * 2 + 1, 4);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 1, m_s, 1);
    cyc(0, 0, 0, 0, 1, 0, m_s * 2, 7);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 1, 7, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 1, i & 1, 0, 0, 0, 0);
      if (i % 3 == 0) cyc(0, 0, 1, 1, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 1, 15, 3);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);

    cyc(1, 1, 1, 1, 1, 1, 0, 3);
    cyc(0, 1, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          $urandom_range(0, 1),
          ($urandom_range(0, 2) == 0) ? 1 : 0,
          $urandom_range(0, 1),
          $urandom_range(0, 15),
          $urandom_range(0, 7));
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
